regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for a single regfile write port. After reset it clears r1..r31 (31 cycles).
// Then it grants one writeback per cycle with zero latency: wb0 has default priority, and a starved wb1 takes the port.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_dest,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_dest,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in,
  output logic        clear_done
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [0:0] r_state;
  logic [4:0] r_clr_idx;
  logic [3:0] r_starve;

  logic w_run;
  logic w_wb0_nz;
  logic w_wb0_z;
  logic w_wb1_nz;
  logic w_wb1_z;
  logic w_wb0_win;
  logic w_wb1_win;

  assign w_run     = (r_state == ST_RUN) && !rst;
  assign w_wb0_nz  = wb0_valid && (wb0_dest != 5'd0);
  assign w_wb0_z   = wb0_valid && (wb0_dest == 5'd0);
  assign w_wb1_nz  = wb1_valid && (wb1_dest != 5'd0);
  assign w_wb1_z   = wb1_valid && (wb1_dest == 5'd0);
  // Writes to r0 are discarded, so they bypass arbitration entirely.
  assign w_wb1_win = w_wb1_nz && (!w_wb0_nz || (r_starve == LIMIT));
  assign w_wb0_win = w_wb0_nz && !w_wb1_win;

  always_comb begin
    wb0_ready  = 1'b0;
    wb1_ready  = 1'b0;
    rf_load    = 1'b0;
    rf_dest    = 5'd0;
    rf_in      = 32'd0;
    clear_done = 1'b0;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        rf_load = 1'b1;
        rf_dest = r_clr_idx;
      end else begin
        clear_done = 1'b1;
        wb0_ready  = w_wb0_z || w_wb0_win;
        wb1_ready  = w_wb1_z || w_wb1_win;
        if (w_wb1_win) begin
          rf_load = 1'b1;
          rf_dest = wb1_dest;
          rf_in   = wb1_data;
        end else if (w_wb0_win) begin
          rf_load = 1'b1;
          rf_dest = wb0_dest;
          rf_in   = wb0_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= 5'd1;
      r_starve  <= 4'd0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + 5'd1;
      r_starve  <= 4'd0;
      if (r_clr_idx == 5'd31) begin
        r_state <= ST_RUN;
      end
    end else begin
      // Counter only tracks an uninterrupted run of lost nonzero-dest cycles.
      if (!wb1_valid || wb1_ready) begin
        r_starve <= 4'd0;
      end else if (w_wb1_nz && (r_starve < LIMIT)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  logic w_unused;
  assign w_unused = w_run;

endmodule
